// File: rtl/acc_bank_fifo_if.sv
// acc_bank_fifo_if: compute, swap and drain signals of the accumulation FIFO.
// ACC_BANK_FIFO_ADD_EN adds the cmp_acc accumulate-on-write strobe.
interface acc_bank_fifo_if #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_in;
    logic              cmp_write;
    logic              cmp_read;
    logic [DATA_W-1:0] cmp_rdata;
    logic              cmp_rvalid;
    logic              cmp_full;
    logic              cmp_empty;
    logic [CNT_W-1:0]  cmp_count;
    logic              swap_req;
    logic              swap_ack;
    logic              out_read;
    logic [DATA_W-1:0] out_data;
    logic              out_rvalid;
    logic              out_empty;
    logic              err_ovf;
    logic              err_unf;
`ifdef ACC_BANK_FIFO_ADD_EN
    logic              cmp_acc;
`endif

    modport master (
`ifdef ACC_BANK_FIFO_ADD_EN
        output cmp_acc,
`endif
        output data_in, cmp_write, cmp_read,
        output swap_req, out_read,
        input  cmp_rdata, cmp_rvalid, cmp_full,
        input  cmp_empty, cmp_count, swap_ack,
        input  out_data, out_rvalid, out_empty,
        input  err_ovf, err_unf
    );

    modport slave (
`ifdef ACC_BANK_FIFO_ADD_EN
        input  cmp_acc,
`endif
        input  data_in, cmp_write, cmp_read,
        input  swap_req, out_read,
        output cmp_rdata, cmp_rvalid, cmp_full,
        output cmp_empty, cmp_count, swap_ack,
        output out_data, out_rvalid, out_empty,
        output err_ovf, err_unf
    );
endinterface

// File: rtl/acc_bank_fifo.sv
// acc_bank_fifo: NUM_BANKS rotating accumulation FIFO with a drain queue.
// Define ACC_BANK_FIFO_ADD_EN for saturating accumulate-on-write (cmp_acc).
module acc_bank_fifo #(
    parameter int  DATA_W    = 24,
    parameter int  DEPTH     = 32,
    parameter int  NUM_BANKS = 2,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int BANK_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            rst,
    acc_bank_fifo_if.slave bus
);
    logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

    logic [AW-1:0]     rd_ptr_q [NUM_BANKS];
    logic [AW-1:0]     rd_ptr_d [NUM_BANKS];
    logic [AW-1:0]     wr_ptr_q [NUM_BANKS];
    logic [AW-1:0]     wr_ptr_d [NUM_BANKS];
    logic [CNT_W-1:0]  cnt_q [NUM_BANKS];
    logic [CNT_W-1:0]  cnt_d [NUM_BANKS];
    logic [BANK_W-1:0] c_q, c_d, d_q, d_d, s_q, s_d;
    logic [DATA_W-1:0] cmp_rdata_q, cmp_rdata_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              cmp_rvalid_q, cmp_rvalid_d;
    logic              out_rvalid_q, out_rvalid_d;
    logic              swap_ack_q, swap_ack_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    logic [CNT_W-1:0]  cnt_c, cnt_o;
    logic              rd_ok, wr_ok, out_pop;
    logic              swap_ok, rel, out_empty;
    logic [DATA_W-1:0] wr_data;

    function automatic logic [BANK_W-1:0] nxt(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

`ifdef ACC_BANK_FIFO_ADD_EN
    logic [DATA_W:0] sum;

    // Sign-extended sum; the top two bits disagree exactly on overflow.
    always_comb begin
        sum = {bus.data_in[DATA_W-1], bus.data_in}
            + {cmp_rdata_q[DATA_W-1], cmp_rdata_q};
        wr_data = bus.data_in;
        if (bus.cmp_acc) begin
            unique case (sum[DATA_W:DATA_W-1])
                2'b01:   wr_data = {1'b0, {(DATA_W-1){1'b1}}};
                2'b10:   wr_data = {1'b1, {(DATA_W-1){1'b0}}};
                default: wr_data = sum[DATA_W-1:0];
            endcase
        end
    end
`else
    assign wr_data = bus.data_in;
`endif

    always_comb begin
        cnt_c     = cnt_q[c_q];
        cnt_o     = cnt_q[d_q];
        out_empty = (s_q == '0) || (cnt_o == '0);
        rd_ok     = bus.cmp_read && (cnt_c != '0);
        wr_ok     = bus.cmp_write
                  && ((cnt_c != CNT_W'(DEPTH)) || rd_ok);
        out_pop   = bus.out_read && !out_empty;
        swap_ok   = bus.swap_req
                  && (s_q < BANK_W'(NUM_BANKS - 1));
        rel       = (s_q != '0) && (cnt_o == '0);

        // With sealed banks pending d never equals c, so the drain
        // update below cannot collide with the compute update.
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_ptr_d[b] = rd_ptr_q[b];
            wr_ptr_d[b] = wr_ptr_q[b];
            cnt_d[b]    = cnt_q[b];
            if (BANK_W'(b) == c_q) begin
                if (rd_ok) rd_ptr_d[b] = rd_ptr_q[b] + AW'(1);
                if (wr_ok) wr_ptr_d[b] = wr_ptr_q[b] + AW'(1);
                cnt_d[b] = cnt_q[b] + CNT_W'(wr_ok) - CNT_W'(rd_ok);
            end
            if ((BANK_W'(b) == d_q) && out_pop) begin
                rd_ptr_d[b] = rd_ptr_q[b] + AW'(1);
                cnt_d[b]    = cnt_q[b] - CNT_W'(1);
            end
        end

        c_d          = swap_ok ? nxt(c_q) : c_q;
        d_d          = rel ? nxt(d_q) : d_q;
        s_d          = s_q + BANK_W'(swap_ok) - BANK_W'(rel);
        cmp_rdata_d  = rd_ok ? mem_q[c_q][rd_ptr_q[c_q]] : cmp_rdata_q;
        cmp_rvalid_d = rd_ok;
        out_data_d   = out_pop ? mem_q[d_q][rd_ptr_q[d_q]] : out_data_q;
        out_rvalid_d = out_pop;
        swap_ack_d   = swap_ok;
        err_ovf_d    = err_ovf_q || (bus.cmp_write && !wr_ok);
        err_unf_d    = err_unf_q || (bus.cmp_read && !rd_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[c_q][wr_ptr_q[c_q]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rd_ptr_q[b] <= '0;
                wr_ptr_q[b] <= '0;
                cnt_q[b]    <= '0;
            end
            c_q          <= '0;
            d_q          <= '0;
            s_q          <= '0;
            cmp_rdata_q  <= '0;
            out_data_q   <= '0;
            cmp_rvalid_q <= 1'b0;
            out_rvalid_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            c_q          <= c_d;
            d_q          <= d_d;
            s_q          <= s_d;
            cmp_rdata_q  <= cmp_rdata_d;
            out_data_q   <= out_data_d;
            cmp_rvalid_q <= cmp_rvalid_d;
            out_rvalid_q <= out_rvalid_d;
            swap_ack_q   <= swap_ack_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
        end
    end

    assign bus.cmp_rdata  = cmp_rdata_q;
    assign bus.cmp_rvalid = cmp_rvalid_q;
    assign bus.cmp_full   = (cnt_c == CNT_W'(DEPTH));
    assign bus.cmp_empty  = (cnt_c == '0);
    assign bus.cmp_count  = cnt_c;
    assign bus.swap_ack   = swap_ack_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_rvalid = out_rvalid_q;
    assign bus.out_empty  = out_empty;
    assign bus.err_ovf    = err_ovf_q;
    assign bus.err_unf    = err_unf_q;
endmodule

// File: tb/tb_acc_bank_fifo.sv
// tb_acc_bank_fifo: directed bench for acc_bank_fifo.
// Drives a 2-bank and a 4-bank instance from one clock.
module tb_acc_bank_fifo;
    localparam int DW = 24;
    localparam int DP = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    acc_bank_fifo_if #(.DATA_W(DW), .DEPTH(DP)) i2 ();
    acc_bank_fifo_if #(.DATA_W(DW), .DEPTH(DP)) i4 ();

    acc_bank_fifo #(.DATA_W(DW), .DEPTH(DP), .NUM_BANKS(2)) dut2 (
        .clk(clk), .rst(rst), .bus(i2)
    );
    acc_bank_fifo #(.DATA_W(DW), .DEPTH(DP), .NUM_BANKS(4)) dut4 (
        .clk(clk), .rst(rst), .bus(i4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i2.data_in = '0; i2.cmp_write = 0; i2.cmp_read = 0;
        i2.swap_req = 0; i2.out_read = 0;
        i4.data_in = '0; i4.cmp_write = 0; i4.cmp_read = 0;
        i4.swap_req = 0; i4.out_read = 0;
`ifdef ACC_BANK_FIFO_ADD_EN
        i2.cmp_acc = 0; i4.cmp_acc = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] f;
        do_reset();
        f = {i2.cmp_empty, i2.out_empty, i2.cmp_full, i2.err_ovf,
             i2.err_unf, i2.swap_ack, i2.cmp_rvalid, i2.out_rvalid};
        checks++;
        if (f !== 8'b1100_0000) begin
            fails++; $display("FAIL reset_flags2: got %b want 11000000", f);
        end
        f = {i4.cmp_empty, i4.out_empty, i4.cmp_full, i4.err_ovf,
             i4.err_unf, i4.swap_ack, i4.cmp_rvalid, i4.out_rvalid};
        checks++;
        if (f !== 8'b1100_0000) begin
            fails++; $display("FAIL reset_flags4: got %b want 11000000", f);
        end
        checks++;
        if (i2.cmp_count !== 0 || i2.cmp_rdata !== 0 || i2.out_data !== 0) begin
            fails++;
            $display("FAIL reset_data: count %0d rdata %0h odata %0h want 0",
                     i2.cmp_count, i2.cmp_rdata, i2.out_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            i2.data_in = DW'(i); i2.cmp_write = 1; cyc();
        end
        i2.cmp_write = 0;
        checks++;
        if (i2.cmp_full !== 1 || i2.cmp_count !== 32 || i2.err_ovf !== 0) begin
            fails++;
            $display("FAIL fill: full %b count %0d ovf %b want 1 32 0",
                     i2.cmp_full, i2.cmp_count, i2.err_ovf);
        end
        i2.data_in = 24'd999; i2.cmp_write = 1; cyc(); i2.cmp_write = 0;
        checks++;
        if (i2.err_ovf !== 1 || i2.cmp_count !== 32) begin
            fails++;
            $display("FAIL overflow: ovf %b count %0d want 1 32",
                     i2.err_ovf, i2.cmp_count);
        end
    endtask

    task automatic test_rw_full();
        logic [DW-1:0] exp;
        i2.data_in = 24'd100; i2.cmp_read = 1; i2.cmp_write = 1;
        cyc();
        i2.cmp_read = 0; i2.cmp_write = 0;
        checks++;
        if (i2.cmp_rvalid !== 1 || i2.cmp_rdata !== 1 || i2.cmp_count !== 32) begin
            fails++;
            $display("FAIL rw_full: rvalid %b rdata %0d count %0d want 1 1 32",
                     i2.cmp_rvalid, i2.cmp_rdata, i2.cmp_count);
        end
        cyc();
        checks++;
        if (i2.cmp_rvalid !== 0) begin
            fails++; $display("FAIL rvalid_pulse: got %b want 0", i2.cmp_rvalid);
        end
        for (int k = 0; k < 32; k++) begin
            exp = (k < 31) ? DW'(k + 2) : 24'd100;
            i2.cmp_read = 1; cyc();
            checks++;
            if (i2.cmp_rvalid !== 1 || i2.cmp_rdata !== exp) begin
                fails++;
                $display("FAIL pop_%0d: rvalid %b data %0d want 1 %0d",
                         k, i2.cmp_rvalid, i2.cmp_rdata, exp);
            end
        end
        i2.cmp_read = 0;
        checks++;
        if (i2.cmp_empty !== 1 || i2.cmp_count !== 0) begin
            fails++;
            $display("FAIL drained: empty %b count %0d want 1 0",
                     i2.cmp_empty, i2.cmp_count);
        end
    endtask

    task automatic test_underflow();
        i2.cmp_read = 1; cyc(); i2.cmp_read = 0;
        checks++;
        if (i2.cmp_rvalid !== 0 || i2.cmp_rdata !== 100 || i2.err_unf !== 1
            || i2.err_ovf !== 1) begin
            fails++;
            $display("FAIL underflow: rv %b data %0d unf %b ovf %b want 0 100 1 1",
                     i2.cmp_rvalid, i2.cmp_rdata, i2.err_unf, i2.err_ovf);
        end
    endtask

    task automatic test_pingpong();
        logic [DW-1:0] exp;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            i2.data_in = DW'(10 * i); i2.cmp_write = 1; cyc();
        end
        i2.cmp_write = 0;
        i2.swap_req = 1; cyc(); i2.swap_req = 0;
        checks++;
        if (i2.swap_ack !== 1 || i2.out_empty !== 0 || i2.cmp_empty !== 1) begin
            fails++;
            $display("FAIL pp_swap: ack %b oempty %b cempty %b want 1 0 1",
                     i2.swap_ack, i2.out_empty, i2.cmp_empty);
        end
        i2.swap_req = 1; i2.out_read = 1;
        for (int k = 0; k < 5; k++) begin
            exp = DW'(10 * (k + 1));
            cyc();
            checks++;
            if (i2.out_rvalid !== 1 || i2.out_data !== exp || i2.swap_ack !== 0) begin
                fails++;
                $display("FAIL pp_drain_%0d: rv %b data %0d ack %b want 1 %0d 0",
                         k, i2.out_rvalid, i2.out_data, i2.swap_ack, exp);
            end
        end
        i2.out_read = 0;
        checks++;
        if (i2.out_empty !== 1) begin
            fails++; $display("FAIL pp_empty: got %b want 1", i2.out_empty);
        end
        cyc();
        checks++;
        if (i2.swap_ack !== 0) begin
            fails++; $display("FAIL pp_bubble: ack %b want 0", i2.swap_ack);
        end
        cyc();
        i2.swap_req = 0;
        checks++;
        if (i2.swap_ack !== 1) begin
            fails++; $display("FAIL pp_reswap: ack %b want 1", i2.swap_ack);
        end
        i2.out_read = 1; cyc(); i2.out_read = 0;
        checks++;
        if (i2.out_rvalid !== 0) begin
            fails++; $display("FAIL pp_read_empty: rv %b want 0", i2.out_rvalid);
        end
    endtask

    task automatic test_banks4();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp [6];
        bit acked;
        int ack_at;
        exp = '{24'd11, 24'd21, 24'd22, 24'd31, 24'd32, 24'd33};
        i4.data_in = 24'd11; i4.cmp_write = 1; i4.swap_req = 1; cyc();
        i4.cmp_write = 0; i4.swap_req = 0;
        checks++;
        if (i4.swap_ack !== 1) begin
            fails++; $display("FAIL b4_swap0: ack %b want 1", i4.swap_ack);
        end
        i4.data_in = 24'd21; i4.cmp_write = 1; cyc();
        i4.data_in = 24'd22; i4.swap_req = 1; cyc();
        i4.cmp_write = 0; i4.swap_req = 0;
        checks++;
        if (i4.swap_ack !== 1) begin
            fails++; $display("FAIL b4_swap1: ack %b want 1", i4.swap_ack);
        end
        i4.data_in = 24'd31; i4.cmp_write = 1; cyc();
        i4.data_in = 24'd32; cyc();
        i4.data_in = 24'd33; i4.swap_req = 1; cyc();
        i4.cmp_write = 0; i4.swap_req = 0;
        checks++;
        if (i4.swap_ack !== 1) begin
            fails++; $display("FAIL b4_swap2: ack %b want 1", i4.swap_ack);
        end
        i4.swap_req = 1; cyc(); i4.swap_req = 0;
        checks++;
        if (i4.swap_ack !== 0 || i4.cmp_empty !== 1 || i4.out_empty !== 0) begin
            fails++;
            $display("FAIL b4_refuse: ack %b cempty %b oempty %b want 0 1 0",
                     i4.swap_ack, i4.cmp_empty, i4.out_empty);
        end
        acked = 0;
        ack_at = -1;
        for (int i = 0; i < 14; i++) begin
            i4.out_read = 1;
            i4.swap_req = !acked;
            cyc();
            if (i4.out_rvalid) q.push_back(i4.out_data);
            if (i4.swap_ack && !acked) begin
                acked = 1; ack_at = i;
            end
        end
        i4.out_read = 0; i4.swap_req = 0;
        checks++;
        if (ack_at !== 2) begin
            fails++; $display("FAIL b4_reaccept: cycle %0d want 2", ack_at);
        end
        checks++;
        if (q.size() !== 6) begin
            fails++; $display("FAIL b4_count: got %0d words want 6", q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (q[k] !== exp[k]) begin
                    fails++;
                    $display("FAIL b4_word_%0d: got %0d want %0d", k, q[k], exp[k]);
                end
            end
        end
        checks++;
        if (i4.out_empty !== 1) begin
            fails++; $display("FAIL b4_empty: got %b want 1", i4.out_empty);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] f;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            i2.data_in = DW'(i); i2.cmp_write = 1; cyc();
        end
        i2.cmp_write = 0;
        i2.swap_req = 1; cyc(); i2.swap_req = 0;
        i2.cmp_read = 1; cyc(); i2.cmp_read = 0;
        checks++;
        if (i2.err_unf !== 1 || i2.cmp_rvalid !== 0) begin
            fails++;
            $display("FAIL md_unf: unf %b rv %b want 1 0", i2.err_unf, i2.cmp_rvalid);
        end
        i2.out_read = 1; cyc();
        checks++;
        if (i2.out_rvalid !== 1 || i2.out_data !== 1) begin
            fails++;
            $display("FAIL md_pop: rv %b data %0d want 1 1",
                     i2.out_rvalid, i2.out_data);
        end
        rst = 1; cyc(); rst = 0; i2.out_read = 0;
        f = {i2.cmp_empty, i2.out_empty, i2.cmp_full, i2.err_ovf,
             i2.err_unf, i2.swap_ack, i2.cmp_rvalid, i2.out_rvalid};
        checks++;
        if (f !== 8'b1100_0000 || i2.cmp_count !== 0 || i2.out_data !== 0) begin
            fails++;
            $display("FAIL md_reset: flags %b count %0d odata %0h want 11000000 0 0",
                     f, i2.cmp_count, i2.out_data);
        end
        i2.out_read = 1; cyc(); i2.out_read = 0;
        checks++;
        if (i2.out_rvalid !== 0) begin
            fails++; $display("FAIL md_after: rv %b want 0", i2.out_rvalid);
        end
    endtask

`ifdef ACC_BANK_FIFO_ADD_EN
    task automatic acc_step(input logic [DW-1:0] d, input logic acc,
                            input logic [DW-1:0] exp, input int id);
        i2.data_in = d; i2.cmp_acc = acc; i2.cmp_write = 1; cyc();
        i2.cmp_write = 0; i2.cmp_acc = 0;
        i2.cmp_read = 1; cyc(); i2.cmp_read = 0;
        checks++;
        if (i2.cmp_rvalid !== 1 || i2.cmp_rdata !== exp) begin
            fails++;
            $display("FAIL acc_%0d: rv %b data %06h want 1 %06h",
                     id, i2.cmp_rvalid, i2.cmp_rdata, exp);
        end
    endtask

    task automatic test_add();
        do_reset();
        acc_step(24'h7FFFF0, 1'b0, 24'h7FFFF0, 0);
        acc_step(24'h000020, 1'b1, 24'h7FFFFF, 1);
        acc_step(24'h800010, 1'b0, 24'h800010, 2);
        acc_step(24'hFFFF00, 1'b1, 24'h800000, 3);
        acc_step(24'h000005, 1'b1, 24'h800005, 4);
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_fill();
        test_rw_full();
        test_underflow();
        test_pingpong();
        test_banks4();
        test_reset_mid_drain();
`ifdef ACC_BANK_FIFO_ADD_EN
        test_add();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/acc_bank_fifo.md
Name: acc_bank_fifo

Overview:
- Parametrised N-bank accumulation FIFO for a PE.
- Generalises the two-bank ping-pong accumulation buffer to NUM_BANKS circular banks.
- One bank is the compute bank. The compute side pops partial sums from it and pushes updated ones back. Sealed banks queue in rotation order and drain through an independent output port.
- Adds explicit swap handshake, per-bank occupancy, full/empty flags and sticky error reporting.

Parameters:
DATA_W, 24, word width.
DEPTH, 32, entries per bank (power of two, >=2).
NUM_BANKS, 2, bank count (>=2).
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not to be overridden).
BANK_W, $clog2(NUM_BANKS) (min 1), bank index width (derived).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
data_in  in  DATA_W  compute-side write data.
cmp_write  in  1  push data_in to tail of compute bank.
cmp_read  in  1  pop head of compute bank.
cmp_rdata  out  DATA_W  registered compute pop data.
cmp_rvalid  out  1  cmp_rdata updated this cycle.
cmp_full  out  1  compute bank count == DEPTH.
cmp_empty  out  1  compute bank count == 0.
cmp_count  out  CNT_W  compute bank occupancy.
swap_req  in  1  seal compute bank, advance to next bank.
swap_ack  out  1  swap accepted this cycle (registered pulse).
out_read  in  1  pop head of drain bank.
out_data  out  DATA_W  registered drain pop data.
out_rvalid  out  1  out_data updated this cycle.
out_empty  out  1  no sealed data available.
err_ovf  out  1  sticky: write to full compute bank.
err_unf  out  1  sticky: compute pop of empty bank.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all bank pointers and counts are 0. Compute bank c=0, drain bank d=0, sealed count s=0. All outputs are 0, except cmp_empty=1 and out_empty=1.
- Bank state: each bank has rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap DEPTH-1 -> 0) and count (0..DEPTH).
- Compute pop:
  - cmp_read with count[c]>0: cmp_rdata <= mem[c][rd_ptr] at next edge, cmp_rvalid=1 for one cycle. Latency is 1.
  - cmp_read with count[c]==0: cmp_rdata holds, cmp_rvalid=0, err_unf set.
- Compute push:
  - cmp_write with count[c]<DEPTH: write data_in at wr_ptr.
  - cmp_write with count[c]==DEPTH: write dropped, err_ovf set. If cmp_read is also asserted, the write is accepted and count is unchanged.
  - cmp_read and cmp_write in the same cycle: both act, count unchanged.
  - A compute write to an empty bank is not readable until the next cycle.
- Swap:
  - swap_req accepted iff s < NUM_BANKS-1.
  - On accept: c <= (c+1) mod NUM_BANKS, s <= s+1, swap_ack=1 next cycle.
  - On refuse: no change, swap_ack=0. The requester holds swap_req until ack.
  - cmp_read/cmp_write in the same cycle as an accepted swap act on the old bank.
  - The new compute bank is empty by construction.
- Drain:
  - out_empty = (s==0) || (count[d]==0).
  - out_read with !out_empty pops bank d. out_data is registered; out_rvalid pulses 1 cycle later.
  - out_read while out_empty: ignored, no error.
  - Bank release: when s>0 and count[d]==0, next edge d <= (d+1) mod NUM_BANKS, s <= s-1. Draining the last word gives a one-cycle bubble before the next sealed bank is visible.
  - Release and an accepted swap in the same cycle: s unchanged, both indices advance.
  - Swap sealing an empty bank: allowed; the bank is released the cycle it becomes d.
- NUM_BANKS=2 reproduces ping-pong: swap is refused until the previously sealed bank is fully drained.
- Sticky errors: clear only on rst.
- Memory: each bank is a flop/SRAM array with no reset on contents. Read data before the first write is don't-care.

Optional Feature:
ACC_BANK_FIFO_ADD_EN.
- Defined:
  - Extra input port cmp_acc (1 bit).
  - When cmp_write && cmp_acc, the stored word is sat(data_in + cmp_rdata), signed two's complement, saturating to +/-(2^(DATA_W-1)) limits.
  - This enables a read-then-accumulate-write one cycle later without an external adder.
- Undefined: no cmp_acc port; the stored word is always data_in.

Test Plan:
- Reset, then 32 cmp_writes of 1..32 -> cmp_full=1, cmp_count=32. A 33rd write sets err_ovf=1; contents unchanged.
- Simultaneous cmp_read+cmp_write on a full bank with value 100 -> accepted, count stays 32. The popped word is 1 (cmp_rvalid next cycle). The tail word becomes 100.
- NUM_BANKS=2: fill bank0 with 5 words, swap_req -> swap_ack=1, out_empty=0. A second swap_req is refused until the 5 out_reads return those 5 words in order, plus a one-cycle bubble.
- NUM_BANKS=4: seal three banks holding 1, 2 and 3 words -> a fourth swap is refused. Draining returns words in bank order; swaps are re-accepted after the first bank is released.
- cmp_read on an empty compute bank -> err_unf=1, cmp_rvalid=0, cmp_rdata unchanged. Assert rst mid-drain -> all counts 0, flags cleared the next cycle.
- ADD_EN defined: write 0x7FFFF0, pop it, then write 0x20 with cmp_acc=1 -> stored word 0x7FFFFF (saturated).
